ifu_fetch: RTL

//  Instruction-fetch stage: owns the PC and fetches one instruction at a time over the imem req/gnt/rsp bus.

---
 rtl/ifu_fetch.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage.
//   Owns the PC and fetches one instruction at a time over a req/gnt/rsp bus.
//   JAL and backward B-type branches are statically predicted taken.
//   Presents {pc, instr, prdt_taken, pc_misalign, bus_err} to ID through a
//   registered valid/ready handshake. EX redirects fetch with flush_i/flush_pc_i.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_o / imem_addr_o         fetch request and address (= pc)
//   imem_gnt_i                       request accepted this cycle
//   imem_rsp_valid_i/_data_i/_err_i  response (one per granted request)
//   flush_i / flush_pc_i             redirect from EX
//   IF_pc_o, ifu_instr_o, ifu_prdt_taken_o, ifu_pc_misalign_o, ifu_bus_err_o
//                                    registered entry toward ID
//   IF_valid_o / ID_ready_i          output handshake
module ifu_fetch #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
  input  logic                   imem_rsp_err_i,
  input  logic                   flush_i,
  input  logic [PC_WIDTH-1:0]    flush_pc_i,
  output logic [PC_WIDTH-1:0]    IF_pc_o,
  output logic [INSTR_WIDTH-1:0] ifu_instr_o,
  output logic                   ifu_prdt_taken_o,
  output logic                   ifu_pc_misalign_o,
  output logic                   ifu_bus_err_o,
  output logic                   IF_valid_o,
  input  logic                   ID_ready_i
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [PC_WIDTH-1:0]    opc_q, opc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   prdt_q, prdt_d;
  logic                   mis_q, mis_d;
  logic                   berr_q, berr_d;

  logic                   out_free_s;
  logic                   req_s;
  logic                   misaligned_s;
  logic                   outstanding_s;
  logic [20:0]            imm_j_s;
  logic [12:0]            imm_b_s;
  logic                   prdt_taken_s;
  logic [PC_WIDTH-1:0]    pc_next_s;

  assign out_free_s   = !valid_q || ID_ready_i;
  assign misaligned_s = (pc_q[1:0] != 2'b00);
  // Requests are gated by out_free so the single outstanding response always
  // finds the output register free when it arrives.
  assign req_s        = (state_q == S_REQ) && !misaligned_s && out_free_s;

  assign imm_j_s = {imem_rsp_data_i[31], imem_rsp_data_i[19:12], imem_rsp_data_i[20],
                    imem_rsp_data_i[30:21], 1'b0};
  assign imm_b_s = {imem_rsp_data_i[31], imem_rsp_data_i[7], imem_rsp_data_i[30:25],
                    imem_rsp_data_i[11:8], 1'b0};

  // Static prediction: JAL always taken, B-type taken only when the offset is negative.
  always_comb begin
    prdt_taken_s = 1'b0;
    pc_next_s    = pc_q + PC_WIDTH'(32'd4);
    if (imem_rsp_data_i[6:0] == 7'b1101111) begin
      prdt_taken_s = 1'b1;
      pc_next_s    = pc_q + {{(PC_WIDTH-21){imm_j_s[20]}}, imm_j_s};
    end else if ((imem_rsp_data_i[6:0] == 7'b1100011) && imem_rsp_data_i[31]) begin
      prdt_taken_s = 1'b1;
      pc_next_s    = pc_q + {{(PC_WIDTH-13){imm_b_s[12]}}, imm_b_s};
    end else begin
      prdt_taken_s = 1'b0;
    end
  end

  // A response is still in flight if we are waiting on one, or are being granted right now.
  assign outstanding_s = (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rsp_valid_i) ||
                         ((state_q == S_REQ) && req_s && imem_gnt_i);

  // Next-state, PC and output-entry logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q && !ID_ready_i;
    opc_d   = opc_q;
    instr_d = instr_q;
    prdt_d  = prdt_q;
    mis_d   = mis_q;
    berr_d  = berr_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misaligned_s) begin
          if (out_free_s) begin
            valid_d = 1'b1;
            opc_d   = pc_q;
            instr_d = NOP;
            prdt_d  = 1'b0;
            mis_d   = 1'b1;
            berr_d  = 1'b0;
            state_d = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end else if (req_s && imem_gnt_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          valid_d = 1'b1;
          opc_d   = pc_q;
          mis_d   = 1'b0;
          if (imem_rsp_err_i) begin
            instr_d = NOP;
            prdt_d  = 1'b0;
            berr_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            instr_d = imem_rsp_data_i;
            prdt_d  = prdt_taken_s;
            berr_d  = 1'b0;
            pc_d    = pc_next_s;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid_i) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DROP;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      valid_d = 1'b0;
      pc_d    = flush_pc_i;
      state_d = outstanding_s ? S_DROP : S_REQ;
    end else begin
      valid_d = valid_d;
    end
  end

  // State, PC and output entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      opc_q   <= '0;
      instr_q <= '0;
      prdt_q  <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      opc_q   <= opc_d;
      instr_q <= instr_d;
      prdt_q  <= prdt_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign imem_req_o        = req_s;
  assign imem_addr_o       = pc_q;
  assign IF_pc_o           = opc_q;
  assign ifu_instr_o       = instr_q;
  assign ifu_prdt_taken_o  = prdt_q;
  assign ifu_pc_misalign_o = mis_q;
  assign ifu_bus_err_o     = berr_q;
  assign IF_valid_o        = valid_q;

endmodule
